latch_event_reader: RTL and testbench



---
 rtl/latch_event_reader.sv | 132 +++++++++++++
 tb/tb_latch_event_reader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/latch_event_reader.sv
// Read-side companion for an asynchronous set/clear latch bank: synchronizes, filters,
// snapshots accepted values, raises an interrupt per change and counts missed changes.
//
// state  | meaning
// IDLE   | synchronized input matches last accepted value
// SETTLE | new value seen, counting consecutive stable cycles
module latch_event_reader #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] latch_q,
    input  logic             rd_en,
    input  logic [1:0]       rd_sel,
    output logic [7:0]       rd_data,
    output logic             irq,
    input  logic             irq_ack
);

    typedef enum logic {IDLE, SETTLE} state_t;

    localparam logic [3:0] STABLE_CNT = 4'(STABLE_CYCLES);

    state_t           state;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] candidate;
    logic [WIDTH-1:0] last_accepted;
    logic [WIDTH-1:0] snapshot;
    logic [3:0]       cnt;
    logic [7:0]       ovf_cnt;
    logic             pending;

    logic             accept;
    logic             pending_clr;
    logic             ovf_clr;
    logic             ovf_hit;
    logic [7:0]       snap_ext;
    logic [7:0]       status;

    always_comb begin
        accept = 1'b0;
        if (state == SETTLE && sync2 != last_accepted && sync2 == candidate &&
            cnt >= STABLE_CNT) begin
            accept = 1'b1;
        end
    end

    assign pending_clr = rd_en && (rd_sel == 2'd0);
    assign ovf_clr     = rd_en && (rd_sel == 2'd2);
    // An accept only counts as missed when the previous one is still unread.
    assign ovf_hit     = accept && pending && !pending_clr;

    always_comb begin
        snap_ext = '0;
        snap_ext[WIDTH-1:0] = snapshot;
    end

    assign status = {4'b0000, (state == SETTLE), (ovf_cnt != 8'd0), irq, pending};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            sync1         <= '0;
            sync2         <= '0;
            candidate     <= '0;
            last_accepted <= '0;
            snapshot      <= '0;
            cnt           <= 4'd0;
            ovf_cnt       <= 8'd0;
            pending       <= 1'b0;
            irq           <= 1'b0;
            rd_data       <= 8'h00;
        end else begin
            sync1 <= latch_q;
            sync2 <= sync1;

            case (state)
                IDLE: begin
                    if (sync2 != last_accepted) begin
                        candidate <= sync2;
                        cnt       <= 4'd1;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (sync2 == last_accepted) begin
                        state <= IDLE;
                    end else if (sync2 != candidate) begin
                        candidate <= sync2;
                        cnt       <= 4'd1;
                    end else if (cnt < STABLE_CNT) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        snapshot      <= candidate;
                        last_accepted <= candidate;
                        state         <= IDLE;
                    end
                end
            endcase

            if (accept) begin
                pending <= 1'b1;
            end else if (pending_clr) begin
                pending <= 1'b0;
            end

            if (accept) begin
                irq <= 1'b1;
            end else if (pending_clr || irq_ack) begin
                irq <= 1'b0;
            end

            if (ovf_clr) begin
                ovf_cnt <= ovf_hit ? 8'd1 : 8'd0;
            end else if (ovf_hit && ovf_cnt != 8'hFF) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end

            if (rd_en) begin
                case (rd_sel)
                    2'd0:    rd_data <= snap_ext;
                    2'd1:    rd_data <= status;
                    2'd2:    rd_data <= ovf_cnt;
                    default: rd_data <= 8'h00;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_latch_event_reader.sv
// Directed bench for latch_event_reader: vector table for steady-state behaviour plus
// hand sequences for latency, saturation, same-cycle collisions and mid-settle reset.
module tb_latch_event_reader;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] latch_q;
    logic       rd_en;
    logic [1:0] rd_sel;
    logic [7:0] rd_data;
    logic       irq;
    logic       irq_ack;

    int n_pass  = 0;
    int n_total = 0;

    latch_event_reader #(.WIDTH(8), .STABLE_CYCLES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .latch_q (latch_q),
        .rd_en   (rd_en),
        .rd_sel  (rd_sel),
        .rd_data (rd_data),
        .irq     (irq),
        .irq_ack (irq_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] latch;
        int         hold;
        logic       do_rd;
        logic [1:0] sel;
        logic [7:0] exp_data;
        logic       exp_irq;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [1:0] sel, output logic [7:0] d);
        rd_en  = 1'b1;
        rd_sel = sel;
        tick();
        rd_en  = 1'b0;
        d      = rd_data;
    endtask

    // Drive a new value; strobe 1 = sel-0 read, 2 = sel-2 read, 3 = irq_ack on the accept edge.
    task automatic change(input logic [7:0] v, input int strobe);
        latch_q = v;
        repeat (6) tick();
        case (strobe)
            1: begin rd_en = 1'b1; rd_sel = 2'd0; end
            2: begin rd_en = 1'b1; rd_sel = 2'd2; end
            3: irq_ack = 1'b1;
            default: ;
        endcase
        tick();
        rd_en   = 1'b0;
        irq_ack = 1'b0;
    endtask

    task automatic apply_vec(input int i);
        logic [7:0] d;
        latch_q = vecs[i].latch;
        repeat (vecs[i].hold) tick();
        if (vecs[i].do_rd) begin
            do_read(vecs[i].sel, d);
            check({vecs[i].name, "_data"}, d, vecs[i].exp_data);
        end
        check({vecs[i].name, "_irq"}, {7'b0, irq}, {7'b0, vecs[i].exp_irq});
    endtask

    initial begin
        logic [7:0] d;

        vecs[0]  = '{"idle_status",   8'h00, 20, 1'b1, 2'd1, 8'h00, 1'b0};
        vecs[1]  = '{"glitch_3c",     8'h3C,  2, 1'b0, 2'd0, 8'h00, 1'b0};
        vecs[2]  = '{"glitch_back",   8'h00, 20, 1'b1, 2'd1, 8'h00, 1'b0};
        vecs[3]  = '{"read_a5",       8'hA5,  0, 1'b1, 2'd0, 8'hA5, 1'b0};
        vecs[4]  = '{"status_a5",     8'hA5,  0, 1'b1, 2'd1, 8'h00, 1'b0};
        vecs[5]  = '{"ovf_a5",        8'hA5,  0, 1'b1, 2'd2, 8'h00, 1'b0};
        vecs[6]  = '{"chg_01",        8'h01, 12, 1'b0, 2'd0, 8'h00, 1'b1};
        vecs[7]  = '{"chg_02_status", 8'h02, 12, 1'b1, 2'd1, 8'h07, 1'b1};
        vecs[8]  = '{"chg_03_read",   8'h03, 12, 1'b1, 2'd0, 8'h03, 1'b0};
        vecs[9]  = '{"ovf_read1",     8'h03,  0, 1'b1, 2'd2, 8'h02, 1'b0};
        vecs[10] = '{"ovf_read2",     8'h03,  0, 1'b1, 2'd2, 8'h00, 1'b0};

        reset_n = 1'b0;
        latch_q = 8'h00;
        rd_en   = 1'b0;
        rd_sel  = 2'd0;
        irq_ack = 1'b0;
        repeat (3) tick();
        check("reset_irq", {7'b0, irq}, 8'h00);
        check("reset_data", rd_data, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 3; i++) apply_vec(i);

        latch_q = 8'hA5;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check($sformatf("latency_e%0d", e), {7'b0, irq}, {7'b0, (e == 7)});
        end

        for (int i = 3; i < 11; i++) apply_vec(i);

        for (int i = 0; i < 300; i++) change((i % 2) ? 8'hAA : 8'h55, 0);
        check("sat_irq", {7'b0, irq}, 8'h01);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("ack_irq", {7'b0, irq}, 8'h00);
        do_read(2'd1, d);
        check("sat_status", d, 8'h05);
        do_read(2'd2, d);
        check("sat_ovf", d, 8'hFF);
        change(8'h55, 0);
        check("reraise_irq", {7'b0, irq}, 8'h01);
        do_read(2'd2, d);
        check("reraise_ovf", d, 8'h01);

        change(8'h66, 1);
        check("acc_rd0_data", rd_data, 8'h55);
        check("acc_rd0_irq", {7'b0, irq}, 8'h01);
        do_read(2'd1, d);
        check("acc_rd0_status", d, 8'h03);
        do_read(2'd0, d);
        check("acc_rd0_snap", d, 8'h66);

        change(8'h77, 0);
        change(8'h78, 0);
        change(8'h79, 2);
        check("acc_rd2_data", rd_data, 8'h01);
        do_read(2'd2, d);
        check("acc_rd2_ovf", d, 8'h01);

        change(8'h7A, 3);
        check("acc_ack_irq", {7'b0, irq}, 8'h01);
        do_read(2'd1, d);
        check("acc_ack_status", d, 8'h07);

        latch_q = 8'h5A;
        repeat (4) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_irq", {7'b0, irq}, 8'h00);
        check("midreset_data", rd_data, 8'h00);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e >= 6) check($sformatf("rel_latency_e%0d", e), {7'b0, irq}, {7'b0, (e == 7)});
        end
        do_read(2'd1, d);
        check("rel_status", d, 8'h03);
        do_read(2'd0, d);
        check("rel_snap", d, 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
